// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared constants for the multi-channel PIO input port
//
// Purpose: register offsets, edge-capture mode encodings and channel limit
//          shared by pio_input_multi and pio_input_channel.
// Ports:   none (package).

package pio_pkg;

  // Low two address bits select the register within a channel.
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_RSVD = 2'd2;
  localparam logic [1:0] REG_EDGE = 2'd3;

  // Edge-capture mode encodings for the EDGE_TYPE parameter.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Largest supported number of channels.
  localparam int MAX_CHANNELS = 4;

endpackage

// File: rtl/pio_input_channel.sv
// rtl/pio_input_channel.sv - one input port: synchroniser, edge capture, irq mask
//
// Purpose: synchronises WIDTH external bits, detects edges against the previous
//          synchronised value, accumulates them in a write-1-to-clear capture
//          register and produces a masked interrupt term.
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   in_bits       raw external inputs for this channel
//   capture_en    low during post-reset warm-up; blocks edge capture
//   mask_we       load irqmask from wdata this cycle
//   edge_clr_we   clear edgecapture bits set in wdata this cycle
//   wdata         write data, already trimmed to WIDTH
//   data_val      synchronised input value
//   mask_val      irqmask register
//   edge_val      edgecapture register
//   irq_term      |(edgecapture & irqmask) for this channel

module pio_input_channel
  import pio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_bits,
  input  logic             capture_en,
  input  logic             mask_we,
  input  logic             edge_clr_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] data_val,
  output logic [WIDTH-1:0] mask_val,
  output logic [WIDTH-1:0] edge_val,
  output logic             irq_term
);

  logic [WIDTH-1:0] sync_val;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign sync_val = in_bits;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
      logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;

      always_comb begin
        sync_d    = sync_q;
        sync_d[0] = in_bits;
        for (int s = 1; s < SYNC_STAGES; s++) begin
          sync_d[s] = sync_q[s-1];
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q <= sync_d;
        end
      end

      assign sync_val = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] rise, fall, det;

  always_comb begin
    rise = sync_val & ~prev_q;
    fall = ~sync_val & prev_q;
    case (EDGE_TYPE)
      EDGE_FALL: det = fall;
      EDGE_ANY:  det = rise | fall;
      default:   det = rise;
    endcase

    prev_d = sync_val;
    mask_d = mask_we ? wdata : mask_q;

    // Clear first, then OR in new edges so a same-cycle edge survives the clear.
    edge_d = edge_q & ~(edge_clr_we ? wdata : '0);
    if (capture_en) begin
      edge_d = edge_d | det;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      mask_q <= '0;
      edge_q <= '0;
    end else begin
      prev_q <= prev_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
    end
  end

  assign data_val = sync_val;
  assign mask_val = mask_q;
  assign edge_val = edge_q;
  assign irq_term = |(edge_q & mask_q);

endmodule

// File: rtl/pio_input_multi.sv
// rtl/pio_input_multi.sv - multi-channel Avalon-MM PIO input port with edge irq
//
// Purpose: CHANNELS independent WIDTH-bit input ports, each with synchroniser,
//          edge capture and irq mask; one registered OR'd interrupt.
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   address    word address: [ADDR_W-1:2] channel, [1:0] register
//   write      write strobe
//   writedata  write data
//   in_port    external inputs, channel c at [c*WIDTH +: WIDTH]
//   readdata   registered read data, latency 1, no read strobe
//   irq        registered interrupt, active high

module pio_input_multi
  import pio_pkg::*;
#(
  parameter  int WIDTH       = 32,
  parameter  int CHANNELS    = 1,
  parameter  int SYNC_STAGES = 2,
  parameter  int EDGE_TYPE   = 0,
  localparam int ADDR_W      = 2 + $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         address,
  input  logic                      write,
  input  logic [31:0]               writedata,
  input  logic [WIDTH*CHANNELS-1:0] in_port,
  output logic [31:0]               readdata,
  output logic                      irq
);

  // Warm-up spans the synchroniser fill plus the prev register, so a line
  // that is already high when reset ends never looks like a fresh edge.
  localparam logic [2:0] WARM_INIT = 3'(SYNC_STAGES + 1);

  logic [2:0]  warm_q, warm_d;
  logic [31:0] readdata_q, readdata_d;
  logic        irq_q, irq_d;

  logic [ADDR_W-1:0] addr_hi;
  logic [1:0]        reg_sel;
  logic              capture_en;

  logic [CHANNELS-1:0]            ch_hit;
  logic [CHANNELS-1:0]            ch_irq;
  logic [CHANNELS-1:0][WIDTH-1:0] ch_data;
  logic [CHANNELS-1:0][WIDTH-1:0] ch_mask;
  logic [CHANNELS-1:0][WIDTH-1:0] ch_edge;

  assign addr_hi    = address >> 2;
  assign reg_sel    = address[1:0];
  assign capture_en = (warm_q == 3'd0);

  // Channel indices at or above CHANNELS match no hit bit, so they read 0
  // and their writes go nowhere.
  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign ch_hit[c] = (addr_hi == ADDR_W'(c));

      pio_input_channel #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
      ) u_ch (
        .clk         (clk),
        .reset       (reset),
        .in_bits     (in_port[c*WIDTH +: WIDTH]),
        .capture_en  (capture_en),
        .mask_we     (write && ch_hit[c] && (reg_sel == REG_MASK)),
        .edge_clr_we (write && ch_hit[c] && (reg_sel == REG_EDGE)),
        .wdata       (writedata[WIDTH-1:0]),
        .data_val    (ch_data[c]),
        .mask_val    (ch_mask[c]),
        .edge_val    (ch_edge[c]),
        .irq_term    (ch_irq[c])
      );
    end
  endgenerate

  always_comb begin
    readdata_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_hit[c]) begin
        case (reg_sel)
          REG_DATA: readdata_d = 32'(ch_data[c]);
          REG_MASK: readdata_d = 32'(ch_mask[c]);
          REG_EDGE: readdata_d = 32'(ch_edge[c]);
          REG_RSVD: readdata_d = '0;
          default:  readdata_d = '0;
        endcase
      end
    end

    irq_d  = |ch_irq;
    warm_d = (warm_q != 3'd0) ? (warm_q - 3'd1) : warm_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_q     <= WARM_INIT;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      warm_q     <= warm_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
